// File: rtl/cpu_check_pkg.sv
// Shared types and constants for the CPU step checker.
// FSM state encoding, error-counter width/saturation and the
// "no failure recorded" sentinel used by first_fail.
package cpu_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_STEP,
        ST_CHECK,
        ST_DONE
    } chk_state_e;

    localparam int unsigned ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Wide all-ones sentinel; users slice it down to their index width.
    localparam logic [31:0] NO_FAIL = '1;

    // Error counter increment that sticks at its maximum value.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/cpu_step_checker_step_timer.sv
// step_timer: counts a run of N consecutive clocks beginning with the
// clock on which load is asserted; expire is high during the Nth clock.
// A load value of 0 is treated as 1.
module step_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: the load clock itself is the first counted clock, so the
    // register holds the number of clocks still remaining after this one.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (load_val == '0) ? '0 : load_val - CNT_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Expiry for the clock currently in progress.
    always_comb begin
        if (load) begin
            expire = (load_val <= CNT_W'(1));
        end else begin
            expire = (cnt_q == CNT_W'(1));
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_step_checker.sv
// cpu_step_checker: holds a core in reset, then steps it one instruction
// at a time and compares a register or status value against an external
// expected-value table after each step.
// Optional build macro HALT_ON_FAIL_EN: stop the run at the first mismatch.
module cpu_step_checker
    import cpu_check_pkg::*;
#(
    parameter int unsigned CYCLES_PER_INSTR = 8,
    parameter int unsigned NUM_CHECKS       = 32,
    parameter int unsigned DATA_W           = 32,
    parameter int unsigned REG_AW           = 4,
    parameter int unsigned RST_HOLD         = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    output logic                          cpu_rst_n,
    output logic                          cpu_clk_en,
    output logic [$clog2(NUM_CHECKS)-1:0] chk_idx,
    input  logic [REG_AW-1:0]             chk_reg,
    input  logic                          chk_is_status,
    input  logic [1:0]                    chk_extra,
    input  logic [DATA_W-1:0]             chk_val,
    output logic [REG_AW-1:0]             dbg_reg_addr,
    input  logic [DATA_W-1:0]             dbg_reg_data,
    input  logic [DATA_W-1:0]             status_in,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [ERR_W-1:0]              err_count,
    output logic [$clog2(NUM_CHECKS)-1:0] first_fail
);

    localparam int unsigned IDX_W    = $clog2(NUM_CHECKS);
    localparam int unsigned STEP_MAX = CYCLES_PER_INSTR + 3;
    localparam int unsigned CNT_MAX  = (STEP_MAX > RST_HOLD) ? STEP_MAX : RST_HOLD;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] FF_NONE  = NO_FAIL[IDX_W-1:0];
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHECKS - 1);

    chk_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [IDX_W-1:0] ff_q, ff_d;
    logic             first_q, first_d;
    logic             cpu_rst_n_q, cpu_rst_n_d;
    logic             clk_en_q, clk_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             mismatch;
    logic             halt;
    logic             tmr_expire;
    logic [CNT_W-1:0] tmr_load_val;

    // The register-file read address simply follows the current table entry.
    assign dbg_reg_addr = chk_reg;

    // Compare the selected observed value against the table entry.
    always_comb begin
        mismatch = chk_is_status ? (status_in != chk_val) : (dbg_reg_data != chk_val);
`ifdef HALT_ON_FAIL_EN
        halt = mismatch;
`else
        halt = 1'b0;
`endif
    end

    // Timer length for the phase being entered. The STEP length is loaded on
    // the first STEP clock (not on the transition edge) because chk_idx only
    // advances on that edge, so chk_extra is valid for the new entry only then.
    always_comb begin
        if (state_q == ST_HOLD) begin
            tmr_load_val = CNT_W'(RST_HOLD);
        end else begin
            tmr_load_val = CNT_W'(CYCLES_PER_INSTR) + CNT_W'(chk_extra);
        end
    end

    step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (first_q),
        .load_val (tmr_load_val),
        .expire   (tmr_expire)
    );

    // Next-state, counter updates and registered output values.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        ff_d    = ff_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_HOLD;
                    idx_d   = '0;
                    err_d   = '0;
                    ff_d    = FF_NONE;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_expire) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_expire) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (mismatch) begin
                        err_d = sat_inc(err_q);
                        if (ff_q == FF_NONE) begin
                            ff_d = idx_q;
                        end
                    end
                    if (halt || (idx_q == IDX_LAST)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_STEP;
                    end
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_HOLD;
                    idx_d   = '0;
                    err_d   = '0;
                    ff_d    = FF_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        first_d     = (state_d != state_q) && ((state_d == ST_HOLD) || (state_d == ST_STEP));
        cpu_rst_n_d = (state_d != ST_HOLD);
        clk_en_d    = (state_d == ST_STEP);
        busy_d      = (state_d == ST_HOLD) || (state_d == ST_STEP) || (state_d == ST_CHECK);
        done_d      = (state_d == ST_DONE);
        pass_d      = (state_d == ST_DONE) && (err_d == '0);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            err_q       <= '0;
            ff_q        <= FF_NONE;
            first_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            clk_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            ff_q        <= ff_d;
            first_q     <= first_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            clk_en_q    <= clk_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign cpu_rst_n  = cpu_rst_n_q;
    assign cpu_clk_en = clk_en_q;
    assign chk_idx    = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule
